// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the shift-chain sequencer.
package shift_seq_ctrl_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_PRESC = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Ticks per transfer: WIDTH bits sent, then DEPTH ticks to flush the chain.
   function automatic int total_ticks(input int width, input int depth);
      return width + depth;
   endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESC enabled cycles.
// A synchronous clear restarts the count so the first tick lands exactly
// PRESC enabled cycles after the clear.
module shift_tick_gen
   import shift_seq_ctrl_pkg::*;
#(
   parameter int PRESC = DEF_PRESC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int              CW   = $clog2(PRESC + 1);
   localparam logic [CW-1:0]   LAST = CW'(PRESC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

   // Next count: clear wins, otherwise count enabled cycles and wrap on the tick.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == LAST) cnt_d = '0;
         else               cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      if (!rst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a serial-in/serial-out flip-flop chain: loads a word on
// start, shifts it out LSB first on prescaled ticks, flushes DEPTH stages and
// reassembles the returning bits into data_o with a done pulse.
// Optional build macro SHIFT_SEQ_CTRL_CHECK_EN keeps a copy of the sent word
// and flags err_o with done_o when the returned word differs.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PRESC = DEF_PRESC
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] data_o,
   output logic             err_o,
   output logic             sd_o,
   output logic             sen_o,
   input  logic             sq_i
);

   localparam int            TOTAL  = total_ticks(WIDTH, DEPTH);
   localparam int            KW     = $clog2(TOTAL + 1);
   localparam logic [KW-1:0] K_SEND = KW'(WIDTH - 1);
   localparam logic [KW-1:0] K_LAST = KW'(TOTAL - 1);
   localparam logic [KW-1:0] K_CAP  = KW'(DEPTH);

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   cap_shift;
   logic             accept;
   logic             tick;

`ifdef SHIFT_SEQ_CTRL_CHECK_EN
   logic [WIDTH-1:0] sent_q, sent_d;
   logic             err_q, err_d;
`endif

   assign accept    = start_i & ~busy_q;
   // New capture bit enters at the MSB so LSB-first bits settle in order.
   assign cap_shift = {sq_i, cap_q};

   shift_tick_gen #(
      .PRESC (PRESC)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (accept),
      .en_i   (busy_q),
      .tick_o (tick)
   );

   // Transfer sequencing: accept, per-tick send/capture, completion.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      sreg_d  = sreg_q;
      cap_d   = cap_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
      sent_d  = sent_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               state_d = SHIFT;
               busy_d  = 1'b1;
               k_d     = '0;
               sreg_d  = data_i;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
               sent_d  = data_i;
`endif
            end
         end
         SHIFT, FLUSH: begin
            if (tick) begin
               // Shifting in zeros makes sd_o drive 0 during the flush ticks.
               sreg_d = sreg_q >> 1;
               k_d    = k_q + 1'b1;
               // Earlier ticks see stale chain contents and are discarded.
               if (k_q >= K_CAP) cap_d = cap_shift[WIDTH:1];
               if (k_q == K_SEND) state_d = FLUSH;
               if (k_q == K_LAST) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  data_d  = cap_d;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
                  err_d   = (cap_d != sent_q);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; the chain itself is never reset from here.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         k_q     <= '0;
         sreg_q  <= '0;
         cap_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
         sent_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         sreg_q  <= sreg_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
         sent_q  <= sent_d;
         err_q   <= err_d;
`endif
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign data_o = data_q;
   assign sd_o   = sreg_q[0];
   assign sen_o  = tick;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
   assign err_o  = err_q;
`else
   assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: two sequencers (PRESC=4 and PRESC=1), each driving a
// 4-stage behavioural chain, checked cycle by cycle against timing and data
// expectations derived from the transfer rules.
module tb_shift_seq_ctrl;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int TT = W + D;

`ifdef SHIFT_SEQ_CTRL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       sel = 1'b0;
   logic       stuck = 1'b0;

   logic       start_a, busy_a, done_a, err_a, sd_a, sen_a, sq_a;
   logic       start_b, busy_b, done_b, err_b, sd_b, sen_b, sq_b;
   logic [7:0] data_a, data_b;
   logic [D-1:0] chain_a = '0;
   logic [D-1:0] chain_b = '0;

   logic       busy_m, done_m, err_m, sd_m, sen_m;
   logic [7:0] data_m;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign busy_m  = sel ? busy_b : busy_a;
   assign done_m  = sel ? done_b : done_a;
   assign err_m   = sel ? err_b  : err_a;
   assign sd_m    = sel ? sd_b   : sd_a;
   assign sen_m   = sel ? sen_b  : sen_a;
   assign data_m  = sel ? data_b : data_a;

   shift_seq_ctrl #(.WIDTH(W), .DEPTH(D), .PRESC(4)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_i(data_in),
      .busy_o(busy_a), .done_o(done_a), .data_o(data_a), .err_o(err_a),
      .sd_o(sd_a), .sen_o(sen_a), .sq_i(sq_a)
   );

   shift_seq_ctrl #(.WIDTH(W), .DEPTH(D), .PRESC(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_i(data_in),
      .busy_o(busy_b), .done_o(done_b), .data_o(data_b), .err_o(err_b),
      .sd_o(sd_b), .sen_o(sen_b), .sq_i(sq_b)
   );

   // Behavioural chains; stage 2 of chain A can be forced to 0.
   always @(posedge clk) begin
      if (sen_a) begin
         chain_a <= {chain_a[D-2:0], sd_a};
         if (stuck) chain_a[2] <= 1'b0;
      end
      if (sen_b) chain_b <= {chain_b[D-2:0], sd_b};
   end
   assign sq_a = chain_a[D-1];
   assign sq_b = chain_b[D-1];

   // One transfer on the selected instance with full per-cycle checking.
   // ign_cycle > 0 raises start with 8'hFF during that busy cycle;
   // abort_cycle > 0 pulls reset in that cycle and checks the abort.
   task automatic xfer(input logic [7:0] word, input bit hold,
                       input int ign_cycle, input int abort_cycle);
      int         p;
      int         n;
      logic       exp_sd;
      logic       exp_sen;
      logic [7:0] exp_data;
      logic       exp_err;
      p        = sel ? 1 : 4;
      exp_data = (stuck && !sel) ? 8'h00 : word;
      exp_err  = CHK && (exp_data != word);
      @(negedge clk);
      start   = 1'b1;
      data_in = word;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      for (int c = 1; c <= TT * p; c++) begin
         n       = (c - 1) / p;
         exp_sd  = (n < W) ? word[n] : 1'b0;
         exp_sen = ((c % p) == 0);
         checks++;
         if (busy_m !== 1'b1) begin
            errors++; $display("FAIL busy c=%0d got=%b want=1", c, busy_m);
         end
         checks++;
         if (sen_m !== exp_sen) begin
            errors++; $display("FAIL sen c=%0d got=%b want=%b", c, sen_m, exp_sen);
         end
         checks++;
         if (sd_m !== exp_sd) begin
            errors++; $display("FAIL sd c=%0d got=%b want=%b", c, sd_m, exp_sd);
         end
         checks++;
         if (done_m !== 1'b0 || err_m !== 1'b0) begin
            errors++; $display("FAIL early_done c=%0d got=%b/%b want=0/0", c, done_m, err_m);
         end
         if (ign_cycle > 0 && c == ign_cycle) begin
            start   = 1'b1;
            data_in = 8'hFF;
         end else if (ign_cycle > 0 && c == ign_cycle + 1 && !hold) begin
            start = 1'b0;
         end
         if (abort_cycle > 0 && c == abort_cycle) begin
            start = 1'b0;
            #2 rst = 1'b0;
            #1;
            checks++;
            if ({busy_m, done_m, err_m, sd_m, sen_m, data_m} !== 13'd0) begin
               errors++;
               $display("FAIL abort_outputs got busy=%b done=%b err=%b sd=%b sen=%b data=%h want all 0",
                        busy_m, done_m, err_m, sd_m, sen_m, data_m);
            end
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < TT * p + 4; i++) begin
               @(posedge clk); #1;
               checks++;
               if (done_m !== 1'b0 || busy_m !== 1'b0) begin
                  errors++;
                  $display("FAIL abort_quiet i=%0d got done=%b busy=%b want 0/0", i, done_m, busy_m);
               end
            end
            return;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done_m !== 1'b1 || busy_m !== 1'b0 || sen_m !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle got done=%b busy=%b sen=%b want 1/0/0", done_m, busy_m, sen_m);
      end
      checks++;
      if (data_m !== exp_data) begin
         errors++; $display("FAIL data got=%h want=%h", data_m, exp_data);
      end
      checks++;
      if (err_m !== exp_err) begin
         errors++; $display("FAIL err got=%b want=%b", err_m, exp_err);
      end
      if (!hold) begin
         @(posedge clk); #1;
         checks++;
         if (done_m !== 1'b0 || err_m !== 1'b0 || busy_m !== 1'b0 || data_m !== exp_data) begin
            errors++;
            $display("FAIL after_done got done=%b err=%b busy=%b data=%h want 0/0/0/%h",
                     done_m, err_m, busy_m, data_m, exp_data);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy_a, done_a, err_a, sd_a, sen_a, data_a} !== 13'd0 ||
          {busy_b, done_b, err_b, sd_b, sen_b, data_b} !== 13'd0) begin
         errors++;
         $display("FAIL reset_values got a=%b%b%b%b%b/%h b=%b%b%b%b%b/%h want all 0",
                  busy_a, done_a, err_a, sd_a, sen_a, data_a,
                  busy_b, done_b, err_b, sd_b, sen_b, data_b);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0 || sen_a !== 1'b0 || sen_b !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b/%b sen=%b/%b want 0", busy_a, busy_b, sen_a, sen_b);
      end
   endtask

   task automatic test_nominal();
      sel = 1'b0;
      xfer(8'hA5, 1'b0, 0, 0);
   endtask

   task automatic test_serial_order();
      sel = 1'b1;
      xfer(8'h01, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      xfer(8'h3C, 1'b1, 0, 0);
      xfer(8'hC3, 1'b0, 0, 0);
      sel = 1'b1;
      xfer(8'h96, 1'b1, 0, 0);
      xfer(8'h69, 1'b0, 0, 0);
   endtask

   task automatic test_busy_ignore_reset();
      sel = 1'b0;
      xfer(8'h77, 1'b0, 10, 20);
      xfer(8'h5A, 1'b0, 0, 0);
   endtask

   task automatic test_random();
      logic [7:0] w;
      for (int i = 0; i < 10; i++) begin
         sel = 1'($urandom_range(0, 1));
         w   = 8'($urandom);
         xfer(w, 1'b0, (i % 3 == 0) ? int'($urandom_range(1, 9)) : 0, 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   task automatic test_check_build();
      sel   = 1'b0;
      stuck = 1'b1;
      xfer(8'hFF, 1'b0, 0, 0);
      stuck = 1'b0;
      xfer(8'hFF, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_serial_order();
      test_back_to_back();
      test_busy_ignore_reset();
      test_random();
      test_check_build();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the serial-in/serial-out D flip-flop shift chain. It accepts a parallel word through a start/busy handshake and paces the chain with a one-cycle shift enable derived from a prescaler; the enable replaces any divided clock. It drives the word into the chain serially, LSB first, and flushes the chain's DEPTH stages. It reassembles the bits returning from the chain output into a parallel word and pulses done.

## Interface
- WIDTH, 8: bits per transferred word (≥1).
- DEPTH, 4: number of flip-flop stages in the controlled chain (≥1).
- PRESC, 4: clock cycles per shift tick (≥1; 1 = tick every cycle).
- clk_i  in  1  single system clock; everything, including the chain, runs on it.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request; accepted on a rising clk_i edge while busy_o is low.
- data_i  in  WIDTH  word to send; sampled on the accepting edge only.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse; data_o and err_o are valid in that cycle.
- data_o  out  WIDTH  word captured from the chain; held until the next done_o.
- err_o  out  1  mismatch flag, valid with done_o (see Configuration).
- sd_o  out  1  serial data to the first chain stage (chain d input).
- sen_o  out  1  shift enable to all chain stages; high for exactly one cycle per tick.
- sq_i  in  1  serial output of the last chain stage.

## Operation
- FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE to SHIFT: start_i is high on an edge while busy_o is low. On that edge:
  - data_i is latched into the shift register.
  - The tick counter k is cleared to 0.
  - The prescaler is cleared.
- On each tick k (0-indexed):
  - sd_o = latched bit k for k < WIDTH, else 0.
  - If k ≥ DEPTH, sq_i is captured as data_o bit (k−DEPTH). sq_i is sampled before the chain updates, so the value is the chain output from before tick k.
- SHIFT to FLUSH: after tick WIDTH−1.
- FLUSH to DONE: after tick WIDTH+DEPTH−1. Total ticks = WIDTH+DEPTH.
- DONE lasts one cycle, then the FSM goes to IDLE. start_i in the DONE cycle is accepted (busy_o is low) and goes directly to SHIFT.
- start_i while busy_o is high is ignored; no queueing.
- The controller never resets or clears the chain. Stale chain contents only affect capture ticks k < DEPTH, which are discarded.
- Arithmetic widths:
  - k: $clog2(WIDTH+DEPTH+1) bits.
  - Prescaler: $clog2(PRESC+1) bits.
  - Neither counter may wrap inside a transfer.

## Timing
- Reset values: busy_o=0, done_o=0, data_o=0, err_o=0, sd_o=0, sen_o=0. The FSM resets to IDLE.
- Reset asserted mid-transfer aborts immediately to IDLE. No done_o is produced and data_o returns to 0.
- Cycle numbering: the first cycle after the accepting edge is cycle 1.
  - busy_o is high for cycles 1 … (WIDTH+DEPTH)·PRESC.
  - sen_o is high in cycles n·PRESC, for n = 1 … WIDTH+DEPTH.
  - sd_o holds the tick's bit for the whole prescaler period ending at that sen_o.
- done_o is high in cycle (WIDTH+DEPTH)·PRESC+1, with busy_o low in the same cycle.
- Back-to-back: a start in the DONE cycle makes busy_o high again in the next cycle. The minimum gap between transfers is therefore 1 cycle.
- PRESC=1: sen_o stays high continuously for WIDTH+DEPTH cycles.

## Configuration
- SHIFT_SEQ_CTRL_CHECK_EN defined: the latched data_i copy is retained. err_o = (data_o ≠ sent word), registered and valid only with done_o. err_o is 0 in all other cycles.
- Not defined: the comparison logic and the retained copy are not built, and err_o is tied to 0. The port list is identical in both builds.

## Structure
- Package shift_seq_ctrl_pkg holds:
  - the state enum (IDLE, SHIFT, FLUSH, DONE);
  - the default parameter constants;
  - a function returning the total tick count WIDTH+DEPTH.
- One sub-module, shift_tick_gen: a prescaler with synchronous clear and enable, outputting a one-cycle tick every PRESC enabled cycles. It shares the async active-low reset.
- The FSM, bit counter, send shift register and capture register live in the top module.

## Test plan
- Nominal loopback: WIDTH=8, DEPTH=4, PRESC=4, 4-stage chain model clocked by clk_i with enable sen_o; data_i=8'hA5 → sen_o pulses at cycles 4, 8, …, 48; done_o at cycle 49; data_o=8'hA5; err_o=0.
- Serial order: data_i=8'h01, PRESC=1 → sd_o=1 only in cycle 1, then 0 in cycles 2–12; data_o=8'h01.
- Back-to-back: start_i held high, 8'h3C then 8'hC3 → second busy_o rises the cycle after the first done_o; data_o values are 8'h3C then 8'hC3, with no extra sen_o pulses between transfers.
- Busy ignore and reset abort: start_i with 8'hFF at cycle 10 of a transfer is ignored; rst_i low at cycle 20 → all outputs 0 asynchronously, no done_o; a following start with 8'h5A completes with data_o=8'h5A.
- Check build (SHIFT_SEQ_CTRL_CHECK_EN): chain model stage 2 stuck at 0, data_i=8'hFF → data_o=8'h00 and err_o=1 for exactly the done_o cycle. Same stimulus without the macro → err_o=0.
